lut_2port_loader: RTL

- Parametrised dual-read lookup table with a streaming bulk-load port, used for the SME match and hash tables.
- Successor to the fixed 2-read ROM: adds read-valid tagging, selectable read latency, and a runtime load FSM.
- Tables can be rewritten in-system, base-relative and with address wrap, without re-synthesising INIT_FILE contents.

---
 rtl/lut_2port_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lut_2port_loader.sv
// Dual-read lookup table with a streaming bulk-load port. Reads are blocked while a
// load is in flight, so the first read after returning to IDLE always sees the new words.
module lut_2port_loader #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 8,
  parameter     INIT_FILE = "",
  parameter bit OUT_REG   = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              rd_ready,
  input  logic              rd_a_valid,
  input  logic [AWIDTH-1:0] rd_a_addr,
  output logic [DWIDTH-1:0] rd_a_data,
  output logic              rd_a_data_valid,
  input  logic              rd_b_valid,
  input  logic [AWIDTH-1:0] rd_b_addr,
  output logic [DWIDTH-1:0] rd_b_data,
  output logic              rd_b_data_valid,
  input  logic              ld_start,
  input  logic [AWIDTH-1:0] ld_base,
  input  logic [AWIDTH:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DWIDTH-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done
);

  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state, state_nxt;
  logic [DWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH:0]   remaining;
  logic              ld_accept;

  logic              wr_en_p0;
  logic [AWIDTH-1:0] wr_addr_p0;
  logic [DWIDTH-1:0] wr_data_p0;

  logic              rd_a_acc, rd_b_acc;
  logic              vld_a_p0, vld_b_p0;
  logic [DWIDTH-1:0] data_a_p0, data_b_p0;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ld_start) state_nxt = (ld_len == '0) ? DONE : LOAD;
      LOAD: if (ld_valid && remaining == 1) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_ready = 1'b0;
    ld_ready = 1'b0;
    ld_busy  = 1'b0;
    ld_done  = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: rd_ready = 1'b1;
        LOAD: begin
          ld_ready = 1'b1;
          ld_busy  = 1'b1;
        end
        DONE: begin
          ld_busy = 1'b1;
          ld_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ld_accept = ld_ready & ld_valid;

  // Load bookkeeping; the pointer wraps naturally at the table size
  always_ff @(posedge clock) begin
    if (state == IDLE && ld_start) begin
      wr_ptr    <= ld_base;
      remaining <= ld_len;
    end else if (ld_accept) begin
      wr_ptr    <= wr_ptr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  // p0: accepted load word waits one edge before committing to the table
  always_ff @(posedge clock) begin
    if (reset) wr_en_p0 <= 1'b0;
    else       wr_en_p0 <= ld_accept;
  end

  always_ff @(posedge clock) begin
    if (ld_accept) begin
      wr_addr_p0 <= wr_ptr;
      wr_data_p0 <= ld_data;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en_p0 && !reset) mem[wr_addr_p0] <= wr_data_p0;
  end

  assign rd_a_acc = rd_a_valid & rd_ready;
  assign rd_b_acc = rd_b_valid & rd_ready;

  // p0: synchronous table read, data held between accepted requests
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_a_p0  <= 1'b0;
      vld_b_p0  <= 1'b0;
      data_a_p0 <= '0;
      data_b_p0 <= '0;
    end else begin
      vld_a_p0 <= rd_a_acc;
      vld_b_p0 <= rd_b_acc;
      if (rd_a_acc) data_a_p0 <= mem[rd_a_addr];
      if (rd_b_acc) data_b_p0 <= mem[rd_b_addr];
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic              vld_a_p1, vld_b_p1;
    logic [DWIDTH-1:0] data_a_p1, data_b_p1;

    // p1: optional output register
    always_ff @(posedge clock) begin
      if (reset) begin
        vld_a_p1  <= 1'b0;
        vld_b_p1  <= 1'b0;
        data_a_p1 <= '0;
        data_b_p1 <= '0;
      end else begin
        vld_a_p1 <= vld_a_p0;
        vld_b_p1 <= vld_b_p0;
        if (vld_a_p0) data_a_p1 <= data_a_p0;
        if (vld_b_p0) data_b_p1 <= data_b_p0;
      end
    end

    assign rd_a_data       = data_a_p1;
    assign rd_a_data_valid = vld_a_p1;
    assign rd_b_data       = data_b_p1;
    assign rd_b_data_valid = vld_b_p1;
  end else begin : g_out_direct
    assign rd_a_data       = data_a_p0;
    assign rd_a_data_valid = vld_a_p0;
    assign rd_b_data       = data_b_p0;
    assign rd_b_data_valid = vld_b_p0;
  end

endmodule
